clk_period_meter: RTL
=====================

Name: clk_period_meter

Overview:
- Measures the division ratio of an incoming divided clock or periodic signal, counted in i_clk cycles.
- Reports the full period and the high time of each cycle of i_sig.
- Used to check divided clocks on-chip, or to measure external periodic inputs, such as the shaker feedback.
- It is the measuring counterpart of the clock divider. A divider ratio of N yields o_period = N.

Parameters:
- CNT_W, 31, width of the counters and results. Matches the divider's 31-bit mode word.
- TIMEOUT_CYC, 100000000, number of i_clk cycles without a rising edge before a timeout is declared. Must be ≤ 2^CNT_W − 1 and ≥ 2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-low reset.
- i_en  in  1  measurement enable.
- i_sig  in  1  signal under measurement. Asynchronous to i_clk.
- o_period  out  CNT_W  last measured period, in i_clk cycles.
- o_high  out  CNT_W  last measured high time, in i_clk cycles.
- o_valid  out  1  one-cycle pulse when o_period/o_high update.
- o_timeout  out  1  sticky no-edge indication.
- o_busy  out  1  high while in RUN.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, counter 0, synchronizer flops 0.
- Input path:
  - i_sig passes through a 2-flop synchronizer and then a previous-value register.
  - rise = s2 & ~prev; fall = ~s2 & prev.
- States: IDLE, RUN.
- IDLE:
  - Counter is held at 0; o_busy = 0.
  - A rise while i_en = 1 → go to RUN and load counter = 1. No o_valid is produced.
- RUN (o_busy = 1):
  - Counter increments every cycle and saturates at 2^CNT_W − 1.
  - fall: capture high_tmp = counter.
  - rise: o_period <= counter, o_high <= high_tmp, o_valid = 1 for one cycle, o_timeout <= 0, counter <= 1.
  - Result: edges N cycles apart give o_period = N exactly; a high time of H cycles gives o_high = H.
  - counter == TIMEOUT_CYC with no rise that cycle → o_timeout <= 1, go to IDLE, no o_valid.
  - If rise and timeout occur in the same cycle, rise wins.
  - i_en = 0 → go to IDLE immediately; o_period, o_high and o_timeout are held; no o_valid.
- Latency: i_sig first sampled high at clock edge k → o_valid is high during the cycle after edge k+2 (3-cycle latency).
- Minimum measurable period: 2 cycles (high 1, low 1). Shorter pulses may be missed; this is not an error.
- Output stability: o_period and o_high change only together with o_valid (or on reset). Values are stable between pulses.
- Reset mid-operation: everything returns to the reset values at once. The first rise after reset only arms the meter.

Optional Feature:
- Macro: CLK_PERIOD_METER_AVG_EN.
- When defined:
  - Period and high values are accumulated over 4 consecutive measurements in (CNT_W+2)-bit accumulators.
  - On every 4th measurement, o_period = sum_period >> 2 and o_high = sum_high >> 2 (truncated), with one o_valid pulse.
  - The accumulators and the 2-bit index clear on reset, on timeout, and on entry to IDLE.
  - o_timeout clears on the 4th measurement.
- When not defined: every measurement is reported individually; no accumulators exist.

Decomposition:
- Shared package clk_meas_pkg:
  - state enum {IDLE, RUN};
  - default CNT_W = 31;
  - AVG_LOG = 2 (averaging depth 4);
  - counter-saturation constant helper.
- Sub-module sig_sync_edge: 2-flop synchronizer, previous-value register, and rise/fall pulse outputs. It has the same clock and reset as the parent and is reusable for other asynchronous inputs.

Test Plan:
1. i_en = 1, i_sig periodic with 3 cycles high / 2 low → from the 2nd rise onward, o_period = 5, o_high = 3, one o_valid every 5 cycles; no o_valid on the 1st rise.
2. i_sig toggling every cycle (high 1, low 1) → o_period = 2, o_high = 1, o_valid every 2 cycles.
3. TIMEOUT_CYC = 20; one rise, then i_sig held 0 → o_timeout = 1 at counter = 20, o_busy = 0, no o_valid. Restart toggling with period 6 → the 1st rise only re-arms; the 2nd rise gives o_period = 6 and o_timeout = 0.
4. i_rst pulsed low mid-RUN with o_period = 5 → all outputs 0 asynchronously. After release, the 1st rise gives no o_valid; the 2nd gives o_period = 5.
5. i_en dropped 2 cycles after a rise → no o_valid, o_period held at its prior value. Re-enable → two rises are needed before the next o_valid.
6. With CLK_PERIOD_METER_AVG_EN, successive periods of 4, 5, 6, 5 with high times 2, 2, 3, 3 → a single o_valid after the 4th period with o_period = 5 and o_high = 2.

Source files
------------

// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock period meter and its input conditioner.
package clk_meas_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int CNT_W_DEF = 31;
  localparam int AVG_LOG   = 2;  // averaging depth of 2**AVG_LOG measurements

  // All-ones value of a w-bit counter, used as its saturation ceiling.
  function automatic logic [63:0] cnt_sat_val(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/clk_period_meter_sig_sync_edge.sv
// Two-flop synchronizer plus previous-value register for an asynchronous input,
// producing single-cycle rise/fall pulses in the i_clk domain.
module sig_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = i_async;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign o_rise = s2_q & ~prev_q;
  assign o_fall = ~s2_q & prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of i_sig in i_clk cycles; a divide-by-N clock reads N.
// Define CLK_PERIOD_METER_AVG_EN to report the truncated mean of every 4 measurements.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 100000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_val(CNT_W));
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);

  logic rise, fall;

  sig_sync_edge u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_sig),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic run_ok, meas, tout;
  assign run_ok = (state_q == RUN) && i_en;
  assign meas   = run_ok && rise;
  assign tout   = run_ok && !rise && (cnt_q == TO_VAL);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_en && rise) state_d = RUN;
      RUN:     if (!i_en || tout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q == RUN);
  end

`ifdef CLK_PERIOD_METER_AVG_EN
  logic [CNT_W+1:0]   acc_p_q, acc_p_d;
  logic [CNT_W+1:0]   acc_h_q, acc_h_d;
  logic [AVG_LOG-1:0] idx_q, idx_d;
  logic [CNT_W+1:0]   sum_p, sum_h;

  assign sum_p = acc_p_q + {2'b00, cnt_q};
  assign sum_h = acc_h_q + {2'b00, high_tmp_q};
`endif

  always_comb begin
    cnt_d      = cnt_q;
    high_tmp_d = high_tmp_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;

    if (state_q == IDLE) begin
      cnt_d = (i_en && rise) ? CNT_W'(1) : '0;
    end else if (!i_en || tout) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (run_ok && fall) high_tmp_d = cnt_q;
    if (tout)           timeout_d  = 1'b1;

`ifdef CLK_PERIOD_METER_AVG_EN
    acc_p_d = acc_p_q;
    acc_h_d = acc_h_q;
    idx_d   = idx_q;
    if (state_d == IDLE) begin
      acc_p_d = '0;
      acc_h_d = '0;
      idx_d   = '0;
    end else if (meas) begin
      if (idx_q == '1) begin
        period_d  = CNT_W'(sum_p >> AVG_LOG);
        high_d    = CNT_W'(sum_h >> AVG_LOG);
        valid_d   = 1'b1;
        timeout_d = 1'b0;
        acc_p_d   = '0;
        acc_h_d   = '0;
        idx_d     = '0;
      end else begin
        acc_p_d = sum_p;
        acc_h_d = sum_h;
        idx_d   = idx_q + AVG_LOG'(1);
      end
    end
`else
    if (meas) begin
      period_d  = cnt_q;
      high_d    = high_tmp_q;
      valid_d   = 1'b1;
      timeout_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q      <= '0;
      high_tmp_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      high_tmp_q <= high_tmp_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef CLK_PERIOD_METER_AVG_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_p_q <= '0;
      acc_h_q <= '0;
      idx_q   <= '0;
    end else begin
      acc_p_q <= acc_p_d;
      acc_h_q <= acc_h_d;
      idx_q   <= idx_d;
    end
  end
`endif

  assign o_period  = period_q;
  assign o_high    = high_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;

endmodule
